// File: rtl/rtc_pkg.sv
// Shared definitions for the RTC bus scheduler: state encoding, register count and
// the RTC address table walked by every burst.
package rtc_pkg;

    localparam int unsigned N_REGS = 9;

    localparam int unsigned IDX_SEG  = 0;
    localparam int unsigned IDX_MIN  = 1;
    localparam int unsigned IDX_HORA = 2;
    localparam int unsigned IDX_DIA  = 3;
    localparam int unsigned IDX_MES  = 4;
    localparam int unsigned IDX_ANO  = 5;
    localparam int unsigned IDX_ST   = 6;
    localparam int unsigned IDX_MT   = 7;
    localparam int unsigned IDX_HT   = 8;

    localparam logic [3:0] IDX_LAST = 4'(N_REGS - 1);

    localparam logic [7:0] ADDR_TBL [N_REGS] = '{
        IDX_SEG:  8'h21,
        IDX_MIN:  8'h22,
        IDX_HORA: 8'h23,
        IDX_DIA:  8'h24,
        IDX_MES:  8'h25,
        IDX_ANO:  8'h26,
        IDX_ST:   8'h41,
        IDX_MT:   8'h42,
        IDX_HT:   8'h43
    };

    typedef enum logic [2:0] {
        StIdle,
        StAddrLo,
        StAddrRel,
        StDataLo,
        StDataRel
    } state_e;

endpackage

// File: rtl/rtc_access_sched_phase_timer.sv
// Loadable down-counter; tc is high while the count sits at zero.
module rtc_phase_timer #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tc
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign tc = (cnt_q == '0);

endmodule

// File: rtl/rtc_access_sched.sv
// Sequences read-refresh and write-back bursts on the multiplexed RTC bus. Pin outputs are
// registered from the current state, so they trail the state register by one clock.
module rtc_access_sched
    import rtc_pkg::*;
#(
    parameter int unsigned T_PHASE = 10,
    parameter int unsigned T_GAP   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        refresh_tick,
    input  logic        wr_req,
    input  logic [71:0] wr_data,
    output logic [71:0] rd_data,
    output logic        rd_valid,
    output logic        wr_done,
    output logic        busy,
    output logic        rtc_cs_n,
    output logic        rtc_rd_n,
    output logic        rtc_wr_n,
    output logic        rtc_ad,
    output logic        rtc_oe,
    output logic [7:0]  rtc_dout,
    input  logic [7:0]  rtc_din
);

    localparam int unsigned TMAX = (T_PHASE > T_GAP) ? T_PHASE : T_GAP;
    localparam int unsigned CW   = $clog2(TMAX + 1);
    localparam logic [CW-1:0] PH_LOAD  = CW'(T_PHASE - 1);
    localparam logic [CW-1:0] GAP_LOAD = CW'(T_GAP - 1);

    state_e state_q, state_d;
    logic [3:0] idx_q, idx_d;
    logic is_wr_q, is_wr_d;
    logic pend_rd_q, pend_rd_d;
    logic pend_wr_q, pend_wr_d;
    logic [N_REGS-1:0][7:0] wbuf_q, wbuf_d;
    logic [N_REGS-1:0][7:0] shadow_q, shadow_d;
    logic samp_q, samp_d;

    logic tmr_load, tmr_tc;
    logic [CW-1:0] tmr_val;

    logic busy_q, busy_d;
    logic rd_valid_q, rd_valid_d;
    logic wr_done_q, wr_done_d;
    logic [N_REGS-1:0][7:0] rd_data_q, rd_data_d;
    logic cs_n_q, cs_n_d, rd_n_q, rd_n_d, wr_n_q, wr_n_d;
    logic ad_q, ad_d, oe_q, oe_d;
    logic [7:0] dout_q, dout_d;
    logic burst_end;

    rtc_phase_timer #(.W(CW)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .tc       (tmr_tc)
    );

    // Acceptance waits for busy to drop, so a queued burst starts after the done pulse.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        is_wr_d   = is_wr_q;
        wbuf_d    = wbuf_q;
        pend_wr_d = pend_wr_q | wr_req;
        pend_rd_d = pend_rd_q | refresh_tick;
        tmr_load  = 1'b0;
        tmr_val   = PH_LOAD;
        unique case (state_q)
            StIdle: begin
                if (!busy_q && (pend_wr_d || pend_rd_d)) begin
                    state_d  = StAddrLo;
                    idx_d    = '0;
                    tmr_load = 1'b1;
                    tmr_val  = PH_LOAD;
                    if (pend_wr_d) begin
                        is_wr_d   = 1'b1;
                        wbuf_d    = wr_data;
                        pend_wr_d = 1'b0;
                    end else begin
                        is_wr_d   = 1'b0;
                        pend_rd_d = 1'b0;
                    end
                end
            end
            StAddrLo: begin
                if (tmr_tc) begin
                    state_d  = StAddrRel;
                    tmr_load = 1'b1;
                    tmr_val  = GAP_LOAD;
                end
            end
            StAddrRel: begin
                if (tmr_tc) begin
                    state_d  = StDataLo;
                    tmr_load = 1'b1;
                    tmr_val  = PH_LOAD;
                end
            end
            StDataLo: begin
                if (tmr_tc) begin
                    state_d  = StDataRel;
                    tmr_load = 1'b1;
                    tmr_val  = GAP_LOAD;
                end
            end
            StDataRel: begin
                if (tmr_tc) begin
                    if (idx_q == IDX_LAST) begin
                        state_d = StIdle;
                    end else begin
                        state_d  = StAddrLo;
                        idx_d    = idx_q + 4'd1;
                        tmr_load = 1'b1;
                        tmr_val  = PH_LOAD;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // samp_q marks the edge that closes the last visible read-strobe cycle.
    always_comb begin
        busy_d     = (state_q != StIdle);
        burst_end  = busy_q && (state_q == StIdle);
        rd_valid_d = burst_end && !is_wr_q;
        wr_done_d  = burst_end && is_wr_q;
        rd_data_d  = rd_valid_d ? shadow_q : rd_data_q;
        samp_d     = (state_q == StDataLo) && tmr_tc && !is_wr_q;
        shadow_d   = shadow_q;
        if (samp_q) begin
            shadow_d[idx_q] = rtc_din;
        end
        cs_n_d = 1'b1;
        rd_n_d = 1'b1;
        wr_n_d = 1'b1;
        ad_d   = ad_q;
        oe_d   = oe_q;
        dout_d = dout_q;
        unique case (state_q)
            StIdle: begin
                ad_d = 1'b0;
                oe_d = 1'b0;
            end
            StAddrLo: begin
                cs_n_d = 1'b0;
                wr_n_d = 1'b0;
                ad_d   = 1'b1;
                oe_d   = 1'b1;
                dout_d = ADDR_TBL[idx_q];
            end
            StDataLo: begin
                cs_n_d = 1'b0;
                ad_d   = 1'b0;
                if (is_wr_q) begin
                    wr_n_d = 1'b0;
                    oe_d   = 1'b1;
                    dout_d = wbuf_q[idx_q];
                end else begin
                    rd_n_d = 1'b0;
                    oe_d   = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            is_wr_q   <= 1'b0;
            pend_rd_q <= 1'b0;
            pend_wr_q <= 1'b0;
            wbuf_q    <= '0;
            shadow_q  <= '0;
            samp_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            is_wr_q   <= is_wr_d;
            pend_rd_q <= pend_rd_d;
            pend_wr_q <= pend_wr_d;
            wbuf_q    <= wbuf_d;
            shadow_q  <= shadow_d;
            samp_q    <= samp_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            busy_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            wr_done_q  <= 1'b0;
            rd_data_q  <= '0;
            cs_n_q     <= 1'b1;
            rd_n_q     <= 1'b1;
            wr_n_q     <= 1'b1;
            ad_q       <= 1'b0;
            oe_q       <= 1'b0;
            dout_q     <= '0;
        end else begin
            busy_q     <= busy_d;
            rd_valid_q <= rd_valid_d;
            wr_done_q  <= wr_done_d;
            rd_data_q  <= rd_data_d;
            cs_n_q     <= cs_n_d;
            rd_n_q     <= rd_n_d;
            wr_n_q     <= wr_n_d;
            ad_q       <= ad_d;
            oe_q       <= oe_d;
            dout_q     <= dout_d;
        end
    end

    assign busy     = busy_q;
    assign rd_valid = rd_valid_q;
    assign wr_done  = wr_done_q;
    assign rd_data  = rd_data_q;
    assign rtc_cs_n = cs_n_q;
    assign rtc_rd_n = rd_n_q;
    assign rtc_wr_n = wr_n_q;
    assign rtc_ad   = ad_q;
    assign rtc_oe   = oe_q;
    assign rtc_dout = dout_q;

endmodule

// File: tb/tb_rtc_access_sched.sv
// Bench for rtc_access_sched: default timing and T_PHASE=T_GAP=1 side by side, both checked
// every cycle against a burst-timeline model plus a few literal expectations.
module tb_rtc_access_sched;

    localparam int NI = 2;
    localparam logic [7:0] TBL [9] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26,
                                       8'h41, 8'h42, 8'h43};

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic tick = 1'b0;
    logic wr_req = 1'b0;
    logic [71:0] wr_data = '0;

    logic [71:0] rd_data [NI];
    logic rd_valid [NI], wr_done [NI], busy [NI];
    logic cs_n [NI], rd_n [NI], wr_n [NI], ad [NI], oe [NI];
    logic [7:0] dout [NI], din [NI], lat [NI], key [NI];

    always #5 clk = ~clk;

    rtc_access_sched #(.T_PHASE(10), .T_GAP(4)) dut0 (
        .clk(clk), .reset(reset), .refresh_tick(tick), .wr_req(wr_req), .wr_data(wr_data),
        .rd_data(rd_data[0]), .rd_valid(rd_valid[0]), .wr_done(wr_done[0]), .busy(busy[0]),
        .rtc_cs_n(cs_n[0]), .rtc_rd_n(rd_n[0]), .rtc_wr_n(wr_n[0]), .rtc_ad(ad[0]),
        .rtc_oe(oe[0]), .rtc_dout(dout[0]), .rtc_din(din[0])
    );

    rtc_access_sched #(.T_PHASE(1), .T_GAP(1)) dut1 (
        .clk(clk), .reset(reset), .refresh_tick(tick), .wr_req(wr_req), .wr_data(wr_data),
        .rd_data(rd_data[1]), .rd_valid(rd_valid[1]), .wr_done(wr_done[1]), .busy(busy[1]),
        .rtc_cs_n(cs_n[1]), .rtc_rd_n(rd_n[1]), .rtc_wr_n(wr_n[1]), .rtc_ad(ad[1]),
        .rtc_oe(oe[1]), .rtc_dout(dout[1]), .rtc_din(din[1])
    );

    function automatic int tp_of(input int i);
        return (i == 0) ? 10 : 1;
    endfunction

    function automatic int tg_of(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    function automatic int blen(input int i);
        return 9 * 2 * (tp_of(i) + tg_of(i));
    endfunction

    function automatic logic [71:0] rd_expect(input logic [7:0] k);
        logic [71:0] r;
        for (int j = 0; j < 9; j++) r[8*j +: 8] = TBL[j] ^ k;
        return r;
    endfunction

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int req_cyc = 0;
    bit chk_en = 1'b0;
    bit rand_key = 1'b0;

    task automatic chk(input string name, input int i, input logic [71:0] act,
                       input logic [71:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s[%0d] got=%h want=%h at %0t", name, i, act, exp, $time);
        end
    endtask

    // Model: each burst is a timeline of cycles counted from its accept edge.
    bit m_act [NI], m_kw [NI], m_prd [NI], m_pwr [NI], e_valid [NI], e_done [NI];
    int m_age [NI];
    logic [71:0] m_wbuf [NI], m_rd [NI];
    logic [7:0] m_bkey [NI];

    task automatic model_step(input int i);
        bit want_wr, want_rd;
        if (!reset) begin
            m_act[i] = 0; m_age[i] = 0; m_prd[i] = 0; m_pwr[i] = 0;
            m_rd[i] = '0; e_valid[i] = 0; e_done[i] = 0;
            return;
        end
        e_valid[i] = 0;
        e_done[i] = 0;
        want_wr = m_pwr[i] | wr_req;
        want_rd = m_prd[i] | tick;
        if (m_act[i]) begin
            m_age[i]++;
            if (m_age[i] == blen(i) + 1) begin
                m_act[i] = 0;
                if (m_kw[i]) e_done[i] = 1;
                else begin
                    e_valid[i] = 1;
                    m_rd[i] = rd_expect(m_bkey[i]);
                end
            end
            m_pwr[i] = want_wr;
            m_prd[i] = want_rd;
        end else if (want_wr) begin
            m_act[i] = 1; m_age[i] = 0; m_kw[i] = 1; m_wbuf[i] = wr_data;
            m_pwr[i] = 0; m_prd[i] = want_rd;
        end else if (want_rd) begin
            m_act[i] = 1; m_age[i] = 0; m_kw[i] = 0;
            if (rand_key) key[i] = 8'($urandom);
            m_bkey[i] = key[i];
            m_prd[i] = 0; m_pwr[i] = 0;
        end
    endtask

    always @(posedge clk) begin
        cyc = cyc + 1;
        for (int i = 0; i < NI; i++) model_step(i);
    end

    task automatic check_cycle(input int i);
        int p, per, r, ridx, ph, tp, tg;
        bit eb, kw;
        tp = tp_of(i);
        tg = tg_of(i);
        eb = m_act[i] && (m_age[i] >= 1);
        kw = m_kw[i];
        chk("busy", i, busy[i], eb);
        chk("rd_valid", i, rd_valid[i], e_valid[i]);
        chk("wr_done", i, wr_done[i], e_done[i]);
        chk("rd_data", i, rd_data[i], m_rd[i]);
        ph = -1;
        ridx = 0;
        if (eb) begin
            p = m_age[i] - 1;
            per = 2 * (tp + tg);
            ridx = p / per;
            r = p % per;
            if (r < tp) ph = 0;
            else if (r < tp + tg) ph = 1;
            else if (r < 2 * tp + tg) ph = 2;
            else ph = 3;
        end
        chk("cs_n", i, cs_n[i], !(ph == 0 || ph == 2));
        chk("wr_n", i, wr_n[i], !(ph == 0 || (ph == 2 && kw)));
        chk("rd_n", i, rd_n[i], !(ph == 2 && !kw));
        if (ph == 0) begin
            chk("ad_addr", i, ad[i], 1'b1);
            chk("oe_addr", i, oe[i], 1'b1);
            chk("dout_addr", i, dout[i], TBL[ridx]);
        end
        if (ph == 2) begin
            chk("ad_data", i, ad[i], 1'b0);
            chk("oe_data", i, oe[i], kw);
            if (kw) chk("dout_data", i, dout[i], m_wbuf[i][8*ridx +: 8]);
        end
    endtask

    // Statistics for the literal expectations.
    int valid_cyc [NI], done_cyc [NI], valid_cnt [NI], done_cnt [NI];
    int addr_ph [NI], wr_low [NI], rd_low [NI], busy_cnt [NI];
    bit prev_addr [NI];

    task automatic clr_stats();
        for (int i = 0; i < NI; i++) begin
            valid_cyc[i] = 0; done_cyc[i] = 0; valid_cnt[i] = 0; done_cnt[i] = 0;
            addr_ph[i] = 0; wr_low[i] = 0; rd_low[i] = 0; busy_cnt[i] = 0;
        end
    endtask

    // RTC device model: latches the address phase, answers addr ^ key while RD is low.
    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (cs_n[i] === 1'b0 && wr_n[i] === 1'b0 && ad[i] === 1'b1) lat[i] = dout[i];
            din[i] = (rd_n[i] === 1'b0) ? (lat[i] ^ key[i]) : 8'($urandom);
        end
        if (chk_en) begin
            for (int i = 0; i < NI; i++) begin
                check_cycle(i);
                if (rd_valid[i]) begin valid_cyc[i] = cyc; valid_cnt[i]++; end
                if (wr_done[i]) begin done_cyc[i] = cyc; done_cnt[i]++; end
                if (!wr_n[i]) wr_low[i]++;
                if (!rd_n[i]) rd_low[i]++;
                if (busy[i]) busy_cnt[i]++;
                if ((ad[i] && !cs_n[i]) && !prev_addr[i]) addr_ph[i]++;
                prev_addr[i] = ad[i] && !cs_n[i];
            end
        end
    end

    task automatic adv(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic pulse(input bit t, input bit w);
        @(posedge clk);
        #2;
        tick = t;
        wr_req = w;
        req_cyc = cyc + 1;
        @(posedge clk);
        #2;
        tick = 0;
        wr_req = 0;
    endtask

    initial begin
        key[0] = 8'h5A;
        key[1] = 8'h5A;
        lat[0] = '0;
        lat[1] = '0;
        clr_stats();
        adv(3);
        reset = 1'b1;
        chk_en = 1'b1;
        chk("rst_busy", 0, busy[0], 1'b0);
        chk("rst_cs_n", 0, cs_n[0], 1'b1);
        chk("rst_rd_n", 0, rd_n[0], 1'b1);
        chk("rst_wr_n", 0, wr_n[0], 1'b1);
        chk("rst_oe", 0, oe[0], 1'b0);
        chk("rst_ad", 0, ad[0], 1'b0);
        chk("rst_dout", 0, dout[0], 8'h00);
        chk("rst_rd_data", 0, rd_data[0], 72'h0);

        // Reset in the middle of a read burst.
        pulse(1, 0);
        adv(97);
        reset = 1'b0;
        adv(1);
        chk("midrst_cs_n", 0, cs_n[0], 1'b1);
        chk("midrst_busy", 0, busy[0], 1'b0);
        reset = 1'b1;
        clr_stats();
        adv(300);
        chk("midrst_no_valid", 0, valid_cnt[0], 0);
        chk("midrst_rd_data", 0, rd_data[0], 72'h0);

        // Single read burst.
        clr_stats();
        pulse(1, 0);
        adv(300);
        chk("rd_latency", 0, valid_cyc[0] - req_cyc, 253);
        chk("rd_latency", 1, valid_cyc[1] - req_cyc, 37);
        chk("rd_value", 0, rd_data[0], 72'h19181B7C7F7E79787B);
        chk("rd_value", 1, rd_data[1], 72'h19181B7C7F7E79787B);
        chk("rd_addr_phases", 0, addr_ph[0], 9);
        chk("rd_rd_low", 0, rd_low[0], 90);
        chk("rd_rd_low", 1, rd_low[1], 9);
        chk("rd_busy_len", 0, busy_cnt[0], 252);
        chk("rd_busy_len", 1, busy_cnt[1], 36);

        // Single write burst.
        clr_stats();
        wr_data = 72'h090807060504030201;
        pulse(0, 1);
        adv(300);
        chk("wr_latency", 0, done_cyc[0] - req_cyc, 253);
        chk("wr_latency", 1, done_cyc[1] - req_cyc, 37);
        chk("wr_wr_low", 0, wr_low[0], 180);
        chk("wr_rd_low", 0, rd_low[0], 0);
        chk("wr_done_cnt", 0, done_cnt[0], 1);

        // Simultaneous tick and write request.
        clr_stats();
        pulse(1, 1);
        adv(600);
        chk("both_wr_latency", 0, done_cyc[0] - req_cyc, 253);
        chk("both_rd_latency", 0, valid_cyc[0] - req_cyc, 507);
        chk("both_rd_latency", 1, valid_cyc[1] - req_cyc, 75);

        // Merged ticks plus a write whose data keeps changing after the request.
        clr_stats();
        pulse(1, 0);
        for (int k = 0; k < 3; k++) begin
            adv(20);
            pulse(1, 0);
        end
        adv(20);
        wr_data = {$urandom, $urandom, 8'($urandom)};
        pulse(0, 1);
        for (int k = 0; k < 1000; k++) begin
            wr_data = {$urandom, $urandom, 8'($urandom)};
            adv(1);
        end
        chk("merge_valid_cnt", 0, valid_cnt[0], 2);
        chk("merge_done_cnt", 0, done_cnt[0], 1);

        // Randomized traffic with occasional resets and random RTC contents.
        rand_key = 1'b1;
        for (int k = 0; k < 4000; k++) begin
            tick = ($urandom_range(59) == 0);
            wr_req = ($urandom_range(89) == 0);
            wr_data = {$urandom, $urandom, 8'($urandom)};
            reset = ($urandom_range(1499) != 0);
            adv(1);
        end
        tick = 0;
        wr_req = 0;
        reset = 1'b1;
        adv(1200);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/rtc_access_sched.md
Name: rtc_access_sched

Overview:
- Sequences all transactions on the external RTC's multiplexed address/data bus (CS, RD, WR, A/D, 8-bit AD).
- Serves two requesters: periodic read-refresh of the 9 time/timer registers, and write-back of user-edited values.
- Sits between the PicoBlaze RTC register file and the RTC pins.
- Bursts are atomic; write has priority over read.

Parameters:
- T_PHASE, 10: clk cycles each strobe (WR/RD) is held low; legal range ≥1.
- T_GAP, 4: clk cycles of release (CS/strobes high) after each phase; legal range ≥1.
- N_REGS, 9: registers per burst; fixed at 9, present for the package table.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- refresh_tick  in  1  one-cycle pulse requesting a read burst
- wr_req  in  1  one-cycle pulse requesting a write burst
- wr_data  in  72  write values; byte i at [8i+7:8i]
- rd_data  out  72  last completed read burst, same packing
- rd_valid  out  1  one-cycle pulse when rd_data is updated
- wr_done  out  1  one-cycle pulse when a write burst completes
- busy  out  1  high while any burst is in progress
- rtc_cs_n  out  1  chip select, active low
- rtc_rd_n  out  1  read strobe, active low
- rtc_wr_n  out  1  write strobe, active low
- rtc_ad  out  1  1 = address phase, 0 = data phase
- rtc_oe  out  1  drive enable for the AD pad (1 = drive rtc_dout)
- rtc_dout  out  8  address or write data
- rtc_din  in  8  read data from the pad

Behaviour:
- Reset (reset=0 at a clk edge):
  - State = IDLE; pend_rd = pend_wr = 0; rd_data = 0.
  - rd_valid = wr_done = busy = 0; rtc_cs_n = rtc_rd_n = rtc_wr_n = 1; rtc_ad = 0; rtc_oe = 0; rtc_dout = 0.
  - Reset mid-burst aborts immediately; rd_data keeps 0; no done pulse.
- Pending flags:
  - refresh_tick sets pend_rd; wr_req sets pend_wr, each one deep.
  - Extra requests while a flag is already set are merged.
  - A flag clears on the edge its burst is accepted.
- Arbitration in IDLE:
  - If pend_wr (or wr_req this cycle): accept write and snapshot wr_data into wbuf.
  - Else if pend_rd (or refresh_tick this cycle): accept read.
  - Simultaneous tick and wr_req: write burst first, then read burst starts on the first IDLE cycle after wr_done.
- States: IDLE -> ADDR_LO -> ADDR_REL -> DATA_LO -> DATA_REL -> (idx<8 ? ADDR_LO with idx+1 : IDLE).
- ADDR_LO, T_PHASE cycles:
  - cs_n=0, wr_n=0, ad=1, oe=1.
  - dout = ADDR_TBL[idx].
- ADDR_REL / DATA_REL, T_GAP cycles:
  - cs_n = wr_n = rd_n = 1.
  - oe and dout hold their previous value.
- DATA_LO, T_PHASE cycles, ad=0, cs_n=0:
  - Write burst: wr_n=0, oe=1, dout = wbuf byte idx.
  - Read burst: rd_n=0, oe=0; rtc_din is sampled into shadow byte idx on the last DATA_LO cycle.
- Timing and outputs:
  - All outputs are registered.
  - A single phase counter reloads to T_PHASE-1 or T_GAP-1 on each state entry.
  - Accept edge E0 → busy=1 from E0+1.
  - Burst length is N_REGS·2·(T_PHASE+T_GAP) cycles; 252 at the defaults.
  - On the edge leaving the final DATA_REL:
    - busy=0 and state returns to IDLE.
    - Read burst: rd_data ← shadow atomically and rd_valid pulses 1 cycle.
    - Write burst: wr_done pulses 1 cycle.
  - Read latency: tick edge to rd_valid high = 253 cycles at the defaults.
  - rd_data never shows a partially updated burst.
- Bursts are never preempted.
- wr_data changes after acceptance do not affect the burst in progress.

Decomposition:
- Package rtc_pkg holds:
  - state enum
  - N_REGS
  - ADDR_TBL[0..8] = 0x21 seg, 0x22 min, 0x23 hora, 0x24 dia, 0x25 mes, 0x26 ano, 0x41 st, 0x42 mt, 0x43 ht
  - byte index constants matching the table order
- One sub-module: rtc_phase_timer, a loadable down-counter with a terminal-count flag, reused for all phases.

Test Plan:
- Reset → all strobes 1, busy=0, rd_data=0; assert reset mid-burst at cycle 100 → strobes high on the next edge, no rd_valid, rd_data stays 0.
- Read: RTC model returns addr^0x5A; single tick → rd_valid at +253 cycles, rd_data[7:0]=0x7B, [15:8]=0x78, …, [71:64]=0x19, with exactly 9 ADDR_LO phases.
- Write: wr_data=0x0908…01 → bus log shows (0x21,0x01)…(0x43,0x09) with wr_n low 10 cycles per phase; wr_done at +253; rd_n stays high throughout.
- Simultaneous tick + wr_req in IDLE → write burst, wr_done, then read burst starting the next cycle; rd_valid at +507 from request.
- Three ticks during a read burst → exactly one extra read burst follows; a wr_req during that burst with wr_data changed afterwards → written bytes equal the value at acceptance.
- T_PHASE=1, T_GAP=1 → burst length 36 cycles; strobes low exactly 1 cycle; sampling still correct.
